// File: rtl/jk_ubus_slave_mem.sv
// UBUS slave memory: decodes a fixed address window, stores bytes internally and
// answers 1/2/4/8-byte bursts with programmable wait states, error and read data.
module jk_ubus_slave_mem #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [1:0]  size,
  input  logic        read,
  input  logic        write,
  input  logic        bip,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_state,
  output logic        error,
  output logic        protocol_err
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH17   = 17'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, DATA} state_e;

  state_e         state_q, state_d;
  logic           dir_q, dir_d;       // 1 = read
  logic           range_q, range_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [3:0]     left_q, left_d;
  logic [3:0]     wait_q, wait_d;
  logic           perr_q, perr_d;
  logic [7:0]     mem_q [DEPTH];
  logic           mem_we;

  logic [3:0]     nbeats;
  logic [16:0]    offset;
  logic           hit;
  logic           range_next;
  logic           beat_done;

  // Offset is taken in 17 bits: a borrow marks addresses below the window, and the
  // end-of-burst sum cannot wrap past 16'hFFFF back into the window.
  assign nbeats     = 4'd1 << size;
  assign offset     = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit        = !offset[16] && ({1'b0, offset[15:0]} < DEPTH17);
  assign range_next = ({1'b0, offset[15:0]} + {13'b0, nbeats} - 17'd1) >= DEPTH17;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    range_d    = range_q;
    ptr_d      = ptr_q;
    left_d     = left_q;
    wait_d     = wait_q;
    perr_d     = perr_q;
    mem_we     = 1'b0;
    beat_done  = 1'b0;
    data_out   = '0;
    data_oe    = 1'b0;
    wait_state = 1'b0;
    error      = 1'b0;
    case (state_q)
      IDLE: begin
        if (read && write) begin
          perr_d = 1'b1;
        end else if ((read || write) && hit) begin
          state_d = DATA;
          dir_d   = read;
          range_d = range_next;
          ptr_d   = offset[AW-1:0];
          left_d  = nbeats;
          wait_d  = WAIT_INIT;
        end
      end
      DATA: begin
        wait_state = (wait_q != 4'd0);
        beat_done  = !wait_state;
        data_oe    = dir_q;
        if (dir_q && !range_q) data_out = mem_q[ptr_q];
        if (!beat_done) begin
          wait_d = wait_q - 4'd1;
        end else begin
          error  = range_q;
          if (bip != (left_q > 4'd1)) perr_d = 1'b1;
          mem_we = !dir_q && !range_q;
          ptr_d  = ptr_q + 1'b1;
          left_d = left_q - 4'd1;
          wait_d = WAIT_INIT;
          if (left_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign protocol_err = perr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      range_q <= 1'b0;
      ptr_q   <= '0;
      left_q  <= '0;
      wait_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      range_q <= range_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      wait_q  <= wait_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_q] <= data_in;
    end
  end

endmodule
